// File: rtl/lcd_init_sequencer_if.sv
// Host-side and PHY-side instruction handshakes of the LCD init sequencer.
// master: the sequencer itself; slave: the host/PHY environment around it.
interface lcd_init_sequencer_if #(
    parameter int INSTR_WIDTH = 10
);
    logic [INSTR_WIDTH-1:0] host_instr_i;
    logic                   host_valid_i;
    logic                   host_ready_o;
    logic [INSTR_WIDTH-1:0] lcd_instr_o;
    logic                   valid_instr_o;
    logic                   ready_instr_i;

    modport master (
        input  host_instr_i, host_valid_i, ready_instr_i,
        output host_ready_o, lcd_instr_o, valid_instr_o
    );

    modport slave (
        output host_instr_i, host_valid_i, ready_instr_i,
        input  host_ready_o, lcd_instr_o, valid_instr_o
    );
endinterface

// File: rtl/lcd_init_sequencer.sv
// HD44780 power-on init sequencer in front of the PHY; afterwards a zero-latency host pass-through.
// Optional macro LCD_INIT_TIMEOUT_EN adds an ISSUE handshake timeout with a sticky init_err_o.
module lcd_init_sequencer #(
    parameter int                     INSTR_WIDTH     = 10,
    parameter int                     PRESCALER_WIDTH = 16,
    parameter int                     DELAY_WIDTH     = 20,
    parameter int                     T_POWERON_100N  = 400000,
    parameter int                     T_WAIT1_100N    = 41000,
    parameter int                     T_WAIT2_100N    = 1000,
    parameter int                     T_INSTR_100N    = 400,
    parameter int                     T_CLEAR_100N    = 15200,
    parameter int                     TIMEOUT_100N    = 10000,
    parameter logic [INSTR_WIDTH-1:0] FUNCTION_SET    = 10'h038,
    parameter logic [INSTR_WIDTH-1:0] ENTRY_MODE      = 10'h006,
    parameter logic [INSTR_WIDTH-1:0] DISPLAY_CTRL    = 10'h00C
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_100n,
    input  logic                       start_i,
    lcd_init_sequencer_if.master       bus,
    output logic                       init_done_o,
    output logic                       busy_o,
    output logic                       init_err_o
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PWR_WAIT = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_DELAY    = 3'd3;
    localparam logic [2:0] S_PASS     = 3'd4;

    logic [2:0]                 state, state_nxt;
    logic [PRESCALER_WIDTH-1:0] pcnt;
    logic [DELAY_WIDTH-1:0]     dcnt;
    logic [3:0]                 step;
    logic                       err;
    logic                       tick, hs, tmo_hit;

    function automatic logic [INSTR_WIDTH-1:0] step_instr(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2: step_instr = INSTR_WIDTH'('h030);
            3'd3:             step_instr = FUNCTION_SET;
            3'd4:             step_instr = INSTR_WIDTH'('h008);
            3'd5:             step_instr = INSTR_WIDTH'('h001);
            3'd6:             step_instr = ENTRY_MODE;
            default:          step_instr = DISPLAY_CTRL;
        endcase
    endfunction

    function automatic logic [DELAY_WIDTH-1:0] step_delay(input logic [2:0] s);
        case (s)
            3'd0:    step_delay = DELAY_WIDTH'(T_WAIT1_100N);
            3'd1:    step_delay = DELAY_WIDTH'(T_WAIT2_100N);
            3'd5:    step_delay = DELAY_WIDTH'(T_CLEAR_100N);
            default: step_delay = DELAY_WIDTH'(T_INSTR_100N);
        endcase
    endfunction

    assign tick = (pcnt == prescaler_100n);
    assign hs   = (state == S_ISSUE) && bus.ready_instr_i;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start_i) state_nxt = S_PWR_WAIT;
            S_PWR_WAIT: if (dcnt == '0) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (hs)           state_nxt = S_DELAY;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_DELAY:    if (dcnt == '0) state_nxt = (step == 4'd8) ? S_PASS : S_ISSUE;
            S_PASS:     if (start_i && !bus.host_valid_i) state_nxt = S_PWR_WAIT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            pcnt  <= '0;
            dcnt  <= '0;
            step  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Prescaler restarts on every state entry so each delay is measured from its own start.
            pcnt  <= (state_nxt != state || tick) ? '0 : pcnt + 1'b1;
            case (state)
                S_IDLE, S_PASS: begin
                    if (state_nxt == S_PWR_WAIT) begin
                        dcnt <= DELAY_WIDTH'(T_POWERON_100N);
                        step <= '0;
                        err  <= 1'b0;
                    end
                end
                S_PWR_WAIT, S_DELAY: begin
                    if (tick && dcnt != '0) dcnt <= dcnt - 1'b1;
                end
                S_ISSUE: begin
                    if (hs) begin
                        dcnt <= step_delay(step[2:0]);
                        step <= step + 1'b1;
                    end else if (tmo_hit) begin
                        err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_INIT_TIMEOUT_EN
    logic [DELAY_WIDTH-1:0] tcnt;

    assign tmo_hit = (state == S_ISSUE) && tick && (tcnt == DELAY_WIDTH'(TIMEOUT_100N - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i)                  tcnt <= '0;
        else if (state_nxt != state) tcnt <= '0;
        else if (tick)              tcnt <= tcnt + 1'b1;
    end
`else
    // No timeout hardware: the comparison is never true, so ISSUE waits indefinitely.
    assign tmo_hit = (TIMEOUT_100N < 0);
`endif

    always_comb begin
        bus.lcd_instr_o   = '0;
        bus.valid_instr_o = 1'b0;
        bus.host_ready_o  = 1'b0;
        case (state)
            S_ISSUE: begin
                bus.lcd_instr_o   = step_instr(step[2:0]);
                bus.valid_instr_o = 1'b1;
            end
            S_PASS: begin
                bus.lcd_instr_o   = bus.host_instr_i;
                bus.valid_instr_o = bus.host_valid_i;
                bus.host_ready_o  = bus.ready_instr_i;
            end
            default: ;
        endcase
    end

    assign busy_o      = (state == S_PWR_WAIT) || (state == S_ISSUE) || (state == S_DELAY);
    assign init_done_o = (state == S_PASS);
    assign init_err_o  = err;
endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Randomized bench for lcd_init_sequencer: init timing/contents against a step-table model,
// host pass-through, reset mid-sequence, and (with LCD_INIT_TIMEOUT_EN) the handshake timeout.
module tb_lcd_init_sequencer;
    localparam int IW    = 10;
    localparam int T_PON = 5;
    localparam int T_W1  = 3;
    localparam int T_W2  = 0;
    localparam int T_INS = 2;
    localparam int T_CLR = 4;
    localparam int T_TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] prescaler_100n = '0;
    logic        init_done_o, busy_o, init_err_o;

    lcd_init_sequencer_if #(.INSTR_WIDTH(IW)) bus();

    lcd_init_sequencer #(
        .INSTR_WIDTH(IW), .T_POWERON_100N(T_PON), .T_WAIT1_100N(T_W1), .T_WAIT2_100N(T_W2),
        .T_INSTR_100N(T_INS), .T_CLEAR_100N(T_CLR), .TIMEOUT_100N(T_TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .prescaler_100n(prescaler_100n), .start_i(start_i),
        .bus(bus), .init_done_o(init_done_o), .busy_o(busy_o), .init_err_o(init_err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference: instruction and post-instruction delay (in 100 ns ticks) for each init step.
    int exp_instr[8] = '{'h030, 'h030, 'h030, 'h038, 'h008, 'h001, 'h006, 'h00C};
    int exp_dly[8]   = '{T_W1, T_W2, T_INS, T_INS, T_INS, T_CLR, T_INS, T_INS};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles a wait of T ticks occupies, counted from the first cycle of the waiting state
    // to the first cycle of the following state.
    function automatic int wait_cycles(input int t, input int p);
        return t * (p + 1) + 1;
    endfunction

    // Advance one negedge at a time until valid (or init_done) is seen; throws in ignored
    // start_i pulses and random ready to show neither disturbs the timing.
    task automatic wait_for(input bit want_done, output int gap, output bit hr_bad);
        gap = 0;
        hr_bad = 1'b0;
        while (!(want_done ? init_done_o : bus.valid_instr_o) && gap < 500) begin
            if (bus.host_ready_o) hr_bad = 1'b1;
            start_i = ($urandom_range(0, 7) == 0);
            bus.ready_instr_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            gap++;
        end
        start_i = 1'b0;
    endtask

    task automatic run_init(input int p, input bit host_pend, input int rst_step);
        int gap, stall;
        bit hr_bad, hr_acc, hold_bad;
        logic [IW-1:0] hi;
        hi = IW'($urandom);
        hr_acc = 1'b0;
        @(negedge clk_i);
        bus.host_valid_i = 1'b0;
        prescaler_100n = 16'(p);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        bus.host_valid_i = host_pend;
        bus.host_instr_i = hi;
        chk("busy_after_start", busy_o, 1);
        chk("err_after_start", init_err_o, 0);
        for (int k = 0; k < 8; k++) begin
            wait_for(1'b0, gap, hr_bad);
            hr_acc |= hr_bad;
            chk($sformatf("gap_step%0d_p%0d", k, p), gap,
                wait_cycles((k == 0) ? T_PON : exp_dly[k-1], p));
            chk($sformatf("instr_step%0d", k), bus.lcd_instr_o, exp_instr[k]);
            if (k == rst_step) begin
                rst_i = 1'b1;
                @(negedge clk_i);
                chk("reset_mid_seq",
                    {bus.valid_instr_o, bus.lcd_instr_o, bus.host_ready_o, init_done_o, busy_o, init_err_o}, 0);
                rst_i = 1'b0;
                return;
            end
            stall = (k == 5 && p == 3) ? 6 : $urandom_range(0, 3);
            hold_bad = 1'b0;
            for (int s = 0; s < stall; s++) begin
                bus.ready_instr_i = 1'b0;
                @(negedge clk_i);
                if (!bus.valid_instr_o || bus.lcd_instr_o !== IW'(exp_instr[k]) || bus.host_ready_o)
                    hold_bad = 1'b1;
            end
            chk($sformatf("hold_step%0d", k), hold_bad, 0);
            bus.ready_instr_i = 1'b1;
            @(negedge clk_i);
            bus.ready_instr_i = 1'b0;
            chk($sformatf("valid_fall_step%0d", k), bus.valid_instr_o, 0);
        end
        wait_for(1'b1, gap, hr_bad);
        hr_acc |= hr_bad;
        chk("gap_to_pass", gap, wait_cycles(T_INS, p));
        chk("pass_flags", {init_done_o, busy_o}, 2'b10);
        chk("host_ready_during_init", hr_acc, 0);
        if (host_pend) begin
            bus.ready_instr_i = 1'b1;
            #1;
            chk("first_pass_accept", {bus.host_ready_o, bus.valid_instr_o, bus.lcd_instr_o}, {2'b11, hi});
        end
    endtask

    task automatic pass_traffic(input int n);
        logic hv, rdy;
        logic [IW-1:0] hi;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            hv  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            hi  = (i < 4) ? IW'('h241) : IW'($urandom);
            if (i < 4) begin
                hv  = 1'b1;
                rdy = i[0];
            end
            bus.host_valid_i  = hv;
            bus.host_instr_i  = hi;
            bus.ready_instr_i = rdy;
            #1;
            chk($sformatf("pass_thru%0d", i),
                {init_done_o, bus.valid_instr_o, bus.lcd_instr_o, bus.host_ready_o}, {1'b1, hv, hi, rdy});
        end
        // start_i must be ignored while a host request is pending
        @(negedge clk_i);
        bus.host_valid_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_ignored_host_valid", {init_done_o, busy_o}, 2'b10);
        bus.host_valid_i = 1'b0;
    endtask

    initial begin
        bus.host_instr_i  = '0;
        bus.host_valid_i  = 1'b0;
        bus.ready_instr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_state",
            {bus.valid_instr_o, bus.lcd_instr_o, bus.host_ready_o, init_done_o, busy_o, init_err_o}, 0);
        rst_i = 1'b0;

        run_init(0, 1'b0, -1);
        pass_traffic(8);
        run_init(3, 1'b1, -1);
        pass_traffic(8);
        run_init($urandom_range(0, 2), 1'b1, 3);
        for (int r = 0; r < 4; r++) begin
            run_init($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
            pass_traffic(10);
        end

`ifdef LCD_INIT_TIMEOUT_EN
        begin
            int gap, cnt, p;
            bit hr_bad;
            p = $urandom_range(0, 2);
            @(negedge clk_i);
            bus.host_valid_i = 1'b0;
            prescaler_100n = 16'(p);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            wait_for(1'b0, gap, hr_bad);
            chk("tmo_first_gap", gap, wait_cycles(T_PON, p));
            bus.ready_instr_i = 1'b0;
            cnt = 0;
            while (bus.valid_instr_o && cnt < 500) begin
                @(negedge clk_i);
                cnt++;
            end
            chk("tmo_valid_cycles", cnt, T_TMO * (p + 1));
            chk("tmo_flags", {init_err_o, busy_o, init_done_o}, 3'b100);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            chk("tmo_err_cleared", {init_err_o, busy_o}, 2'b01);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
